mem_alloc: RTL and testbench

Arbiter and sequencer for the single byte-wide RAM/IO port, shared by instruction fetch, the load/store buffer read path and the load/store buffer write path. Each accepted request is a 1-, 2- or 4-byte little-endian access, serialised into one byte per cycle on the RAM port. The block returns the assembled word, or a completion pulse for writes. It also enforces the IO-buffer-full stall for memory-mapped output.

---
 rtl/mem_alloc.sv | 194 +++++++++++++++++++
 tb/tb_mem_alloc.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_alloc.sv
// mem_alloc: arbitrates fetch / load / store onto the single byte-wide RAM port
// and serialises each 1-, 2- or 4-byte little-endian access one byte per cycle.
module mem_alloc (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_branch_in,
  input  logic        io_buffer_full_in,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        if_to_alloc_en_in,
  input  logic [31:0] if_a_in,
  output logic        alloc_to_if_gr_out,
  output logic        alloc_to_if_en_out,
  output logic [31:0] if_d_out,
  input  logic        lsb_to_alloc_r_en_in,
  input  logic [1:0]  lsb_r_offset_in,
  input  logic [31:0] lsb_r_a_in,
  output logic        alloc_to_lsb_r_gr_out,
  output logic        alloc_to_lsb_r_en_out,
  output logic [31:0] lsb_d_out,
  input  logic        lsb_to_alloc_w_en_in,
  input  logic [1:0]  lsb_w_offset_in,
  input  logic [31:0] lsb_w_a_in,
  input  logic [31:0] lsb_d_in,
  output logic        alloc_to_lsb_w_gr_out,
  output logic        alloc_to_lsb_w_en_out
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_READ, S_WRITE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        if_gr_q, if_gr_d, if_en_q, if_en_d;
  logic        r_gr_q, r_gr_d, r_en_q, r_en_d;
  logic        w_gr_q, w_gr_d, w_en_q, w_en_d;
  logic [31:0] if_d_q, if_d_d, lsb_d_q, lsb_d_d;

  logic        w_ok;
  logic [1:0]  cnt_nx;
  logic [31:0] word;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    off_d      = off_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    if_d_d     = if_d_q;
    lsb_d_d    = lsb_d_q;
    if_gr_d    = 1'b0;
    if_en_d    = 1'b0;
    r_gr_d     = 1'b0;
    r_en_d     = 1'b0;
    w_gr_d     = 1'b0;
    w_en_d     = 1'b0;
    // An IO store waits while the UART buffer is full; others may pass it.
    w_ok   = lsb_to_alloc_w_en_in &&
             !((lsb_w_a_in[17:16] == 2'b11) && io_buffer_full_in);
    cnt_nx = cnt_q + 2'd1;
    word   = rdata_q;
    word[{cnt_q, 3'b000} +: 8] = mem_din;

    unique case (state_q)
      S_IDLE: begin
        if (w_ok) begin
          state_d    = S_WRITE;
          base_d     = lsb_w_a_in;
          off_d      = lsb_w_offset_in;
          wdata_d    = lsb_d_in;
          cnt_d      = '0;
          mem_a_d    = lsb_w_a_in;
          mem_dout_d = lsb_d_in[7:0];
          mem_wr_d   = 1'b1;
          w_gr_d     = 1'b1;
        end else if (!clear_branch_in && lsb_to_alloc_r_en_in) begin
          state_d  = S_READ;
          base_d   = lsb_r_a_in;
          off_d    = lsb_r_offset_in;
          cnt_d    = '0;
          rdata_d  = '0;
          mem_a_d  = lsb_r_a_in;
          mem_wr_d = 1'b0;
          r_gr_d   = 1'b1;
        end else if (!clear_branch_in && if_to_alloc_en_in) begin
          state_d  = S_FETCH;
          base_d   = if_a_in;
          off_d    = 2'd3;
          cnt_d    = '0;
          rdata_d  = '0;
          mem_a_d  = if_a_in;
          mem_wr_d = 1'b0;
          if_gr_d  = 1'b1;
        end
      end
      S_FETCH, S_READ: begin
        if (clear_branch_in) begin
          state_d = S_IDLE;
        end else if (cnt_q == off_q) begin
          state_d = S_IDLE;
          if (state_q == S_FETCH) begin
            if_en_d = 1'b1;
            if_d_d  = word;
          end else begin
            r_en_d  = 1'b1;
            lsb_d_d = word;
          end
        end else begin
          cnt_d   = cnt_nx;
          rdata_d = word;
          mem_a_d = base_q + {30'b0, cnt_nx};
        end
      end
      S_WRITE: begin
        if (cnt_q == off_q) begin
          state_d  = S_IDLE;
          mem_wr_d = 1'b0;
          w_en_d   = 1'b1;
        end else begin
          cnt_d      = cnt_nx;
          mem_a_d    = base_q + {30'b0, cnt_nx};
          mem_dout_d = wdata_q[{cnt_nx, 3'b000} +: 8];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      off_q      <= '0;
      base_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
      if_d_q     <= '0;
      lsb_d_q    <= '0;
      if_gr_q    <= 1'b0;
      if_en_q    <= 1'b0;
      r_gr_q     <= 1'b0;
      r_en_q     <= 1'b0;
      w_gr_q     <= 1'b0;
      w_en_q     <= 1'b0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      off_q      <= off_d;
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      if_d_q     <= if_d_d;
      lsb_d_q    <= lsb_d_d;
      if_gr_q    <= if_gr_d;
      if_en_q    <= if_en_d;
      r_gr_q     <= r_gr_d;
      r_en_q     <= r_en_d;
      w_gr_q     <= w_gr_d;
      w_en_q     <= w_en_d;
    end
  end

  assign mem_a                 = mem_a_q;
  assign mem_dout              = mem_dout_q;
  assign mem_wr                = mem_wr_q;
  assign alloc_to_if_gr_out    = if_gr_q;
  assign alloc_to_if_en_out    = if_en_q;
  assign if_d_out              = if_d_q;
  assign alloc_to_lsb_r_gr_out = r_gr_q;
  assign alloc_to_lsb_r_en_out = r_en_q;
  assign lsb_d_out             = lsb_d_q;
  assign alloc_to_lsb_w_gr_out = w_gr_q;
  assign alloc_to_lsb_w_en_out = w_en_q;

endmodule

// File: tb/tb_mem_alloc.sv
// Self-checking bench for mem_alloc: directed scenarios plus randomized
// request mixes checked against a byte-array memory model.
module tb_mem_alloc;
  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear_branch_in, io_buffer_full_in;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        if_to_alloc_en_in;
  logic [31:0] if_a_in;
  logic        alloc_to_if_gr_out, alloc_to_if_en_out;
  logic [31:0] if_d_out;
  logic        lsb_to_alloc_r_en_in;
  logic [1:0]  lsb_r_offset_in;
  logic [31:0] lsb_r_a_in;
  logic        alloc_to_lsb_r_gr_out, alloc_to_lsb_r_en_out;
  logic [31:0] lsb_d_out;
  logic        lsb_to_alloc_w_en_in;
  logic [1:0]  lsb_w_offset_in;
  logic [31:0] lsb_w_a_in, lsb_d_in;
  logic        alloc_to_lsb_w_gr_out, alloc_to_lsb_w_en_out;

  logic [7:0]  model_mem [4096];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  mem_alloc dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .clear_branch_in(clear_branch_in), .io_buffer_full_in(io_buffer_full_in),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .if_to_alloc_en_in(if_to_alloc_en_in), .if_a_in(if_a_in),
    .alloc_to_if_gr_out(alloc_to_if_gr_out), .alloc_to_if_en_out(alloc_to_if_en_out),
    .if_d_out(if_d_out),
    .lsb_to_alloc_r_en_in(lsb_to_alloc_r_en_in), .lsb_r_offset_in(lsb_r_offset_in),
    .lsb_r_a_in(lsb_r_a_in),
    .alloc_to_lsb_r_gr_out(alloc_to_lsb_r_gr_out), .alloc_to_lsb_r_en_out(alloc_to_lsb_r_en_out),
    .lsb_d_out(lsb_d_out),
    .lsb_to_alloc_w_en_in(lsb_to_alloc_w_en_in), .lsb_w_offset_in(lsb_w_offset_in),
    .lsb_w_a_in(lsb_w_a_in), .lsb_d_in(lsb_d_in),
    .alloc_to_lsb_w_gr_out(alloc_to_lsb_w_gr_out), .alloc_to_lsb_w_en_out(alloc_to_lsb_w_en_out)
  );

  initial forever #5 clk_in = ~clk_in;

  // RAM byte for the address currently on the port, sampled at the next edge.
  assign mem_din = model_mem[mem_a[11:0]];

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [1:0] off);
    logic [31:0] w, p;
    w = '0;
    for (int i = 0; i <= int'(off); i++) begin
      p = a + 32'(i);
      w[8*i +: 8] = model_mem[p[11:0]];
    end
    return w;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [1:0] off, input logic [31:0] d);
    logic [31:0] p;
    for (int i = 0; i <= int'(off); i++) begin
      p = a + 32'(i);
      model_mem[p[11:0]] = d[8*i +: 8];
    end
  endtask

  function automatic logic [1:0] pick_off();
    case ($urandom_range(0, 2))
      0:       return 2'd0;
      1:       return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  task automatic test_reset();
    rst_in = 1'b1; rdy_in = 1'b1; clear_branch_in = 1'b0; io_buffer_full_in = 1'b0;
    if_to_alloc_en_in = 1'b0; if_a_in = '0;
    lsb_to_alloc_r_en_in = 1'b0; lsb_r_offset_in = '0; lsb_r_a_in = '0;
    lsb_to_alloc_w_en_in = 1'b0; lsb_w_offset_in = '0; lsb_w_a_in = '0; lsb_d_in = '0;
    for (int i = 0; i < 4096; i++) model_mem[i] = 8'($urandom);
    tick(); tick();
    n_cmp++; if ({mem_a, mem_dout, mem_wr} !== 41'd0) begin n_bad++;
      $display("FAIL reset_port: got %h want 0", {mem_a, mem_dout, mem_wr}); end
    n_cmp++; if ({alloc_to_if_gr_out, alloc_to_if_en_out, alloc_to_lsb_r_gr_out,
                  alloc_to_lsb_r_en_out, alloc_to_lsb_w_gr_out, alloc_to_lsb_w_en_out} !== 6'd0) begin
      n_bad++; $display("FAIL reset_pulses: nonzero pulse outputs, want 0"); end
    n_cmp++; if ({if_d_out, lsb_d_out} !== 64'd0) begin n_bad++;
      $display("FAIL reset_data: got %h want 0", {if_d_out, lsb_d_out}); end
    rst_in = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    model_mem[12'h000] = 8'h13; model_mem[12'h001] = 8'h05;
    model_mem[12'h002] = 8'h00; model_mem[12'h003] = 8'h00;
    if_to_alloc_en_in = 1'b1; if_a_in = 32'h1000;
    tick();
    n_cmp++; if ({alloc_to_if_gr_out, mem_a, mem_wr} !== {1'b1, 32'h1000, 1'b0}) begin n_bad++;
      $display("FAIL fetch_grant: gr=%b a=%h wr=%b want gr=1 a=00001000 wr=0",
               alloc_to_if_gr_out, mem_a, mem_wr); end
    if_to_alloc_en_in = 1'b0;
    for (int k = 1; k < 4; k++) begin
      tick();
      n_cmp++; if ({alloc_to_if_gr_out, alloc_to_if_en_out, mem_a} !== {2'b00, 32'h1000 + 32'(k)}) begin
        n_bad++; $display("FAIL fetch_addr%0d: gr=%b done=%b a=%h", k,
                          alloc_to_if_gr_out, alloc_to_if_en_out, mem_a); end
    end
    tick();
    n_cmp++; if ({alloc_to_if_en_out, if_d_out} !== {1'b1, 32'h0000_0513}) begin n_bad++;
      $display("FAIL fetch_done: done=%b d=%h want 1 00000513", alloc_to_if_en_out, if_d_out); end
    tick();
    n_cmp++; if (alloc_to_if_en_out !== 1'b0) begin n_bad++;
      $display("FAIL fetch_pulse_width: done=%b want 0", alloc_to_if_en_out); end
  endtask

  task automatic test_store_then_load();
    logic [31:0] d;
    d = 32'hDEAD_BEEF;
    lsb_to_alloc_w_en_in = 1'b1; lsb_w_a_in = 32'h20; lsb_w_offset_in = 2'd3; lsb_d_in = d;
    lsb_to_alloc_r_en_in = 1'b1; lsb_r_a_in = 32'h20; lsb_r_offset_in = 2'd3;
    tick();
    n_cmp++; if ({alloc_to_lsb_w_gr_out, alloc_to_lsb_r_gr_out} !== 2'b10) begin n_bad++;
      $display("FAIL sl_priority: wgr=%b rgr=%b want 1 0", alloc_to_lsb_w_gr_out, alloc_to_lsb_r_gr_out); end
    lsb_to_alloc_w_en_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      n_cmp++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h20 + 32'(k), d[8*k +: 8]}) begin n_bad++;
        $display("FAIL sl_wbyte%0d: wr=%b a=%h dout=%h want 1 %h %h", k, mem_wr, mem_a, mem_dout,
                 32'h20 + 32'(k), d[8*k +: 8]); end
    end
    tick();
    n_cmp++; if ({mem_wr, alloc_to_lsb_w_en_out, alloc_to_lsb_r_gr_out} !== 3'b010) begin n_bad++;
      $display("FAIL sl_wdone: wr=%b done=%b rgr=%b want 0 1 0", mem_wr, alloc_to_lsb_w_en_out,
               alloc_to_lsb_r_gr_out); end
    model_write(32'h20, 2'd3, d);
    tick();
    n_cmp++; if ({alloc_to_lsb_r_gr_out, mem_a} !== {1'b1, 32'h20}) begin n_bad++;
      $display("FAIL sl_rgrant_t5: gr=%b a=%h want 1 00000020", alloc_to_lsb_r_gr_out, mem_a); end
    lsb_to_alloc_r_en_in = 1'b0;
    tick(); tick(); tick(); tick();
    n_cmp++; if ({alloc_to_lsb_r_en_out, lsb_d_out} !== {1'b1, d}) begin n_bad++;
      $display("FAIL sl_rdata: done=%b d=%h want 1 %h", alloc_to_lsb_r_en_out, lsb_d_out, d); end
    tick();
  endtask

  task automatic test_lb();
    int unsigned extra;
    model_mem[12'h007] = 8'h80; model_mem[12'h008] = 8'hAA;
    lsb_to_alloc_r_en_in = 1'b1; lsb_r_a_in = 32'h7; lsb_r_offset_in = 2'd0;
    tick();
    n_cmp++; if ({alloc_to_lsb_r_gr_out, mem_a} !== {1'b1, 32'h7}) begin n_bad++;
      $display("FAIL lb_grant: gr=%b a=%h", alloc_to_lsb_r_gr_out, mem_a); end
    lsb_to_alloc_r_en_in = 1'b0;
    extra = 0;
    tick();
    if (mem_a === 32'h8) extra++;
    n_cmp++; if ({alloc_to_lsb_r_en_out, lsb_d_out} !== {1'b1, 32'h80}) begin n_bad++;
      $display("FAIL lb_done: done=%b d=%h want 1 00000080", alloc_to_lsb_r_en_out, lsb_d_out); end
    tick();
    if (mem_a === 32'h8) extra++;
    n_cmp++; if (extra !== 0) begin n_bad++;
      $display("FAIL lb_single_byte: extra addresses %0d want 0", extra); end
  endtask

  task automatic test_io_stall();
    io_buffer_full_in = 1'b1;
    lsb_to_alloc_w_en_in = 1'b1; lsb_w_a_in = 32'h0003_0000; lsb_w_offset_in = 2'd0; lsb_d_in = 32'h41;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if ({alloc_to_lsb_w_gr_out, mem_wr} !== 2'b00) begin n_bad++;
        $display("FAIL io_stall%0d: gr=%b wr=%b want 0 0", i, alloc_to_lsb_w_gr_out, mem_wr); end
    end
    io_buffer_full_in = 1'b0;
    tick();
    n_cmp++; if ({alloc_to_lsb_w_gr_out, mem_wr, mem_a, mem_dout} !== {2'b11, 32'h0003_0000, 8'h41}) begin
      n_bad++; $display("FAIL io_grant: gr=%b wr=%b a=%h dout=%h", alloc_to_lsb_w_gr_out, mem_wr,
                        mem_a, mem_dout); end
    lsb_to_alloc_w_en_in = 1'b0;
    tick();
    n_cmp++; if ({mem_wr, alloc_to_lsb_w_en_out} !== 2'b01) begin n_bad++;
      $display("FAIL io_done: wr=%b done=%b want 0 1", mem_wr, alloc_to_lsb_w_en_out); end
    model_write(32'h0003_0000, 2'd0, 32'h41);
    tick();
  endtask

  task automatic test_clear_branch();
    logic [31:0] d;
    lsb_to_alloc_r_en_in = 1'b1; lsb_r_a_in = 32'h200; lsb_r_offset_in = 2'd3;
    tick();
    lsb_to_alloc_r_en_in = 1'b0;
    tick(); tick();
    clear_branch_in = 1'b1;
    tick();
    clear_branch_in = 1'b0;
    n_cmp++; if (alloc_to_lsb_r_en_out !== 1'b0) begin n_bad++;
      $display("FAIL clr_no_done: done=%b want 0", alloc_to_lsb_r_en_out); end
    if_to_alloc_en_in = 1'b1; if_a_in = 32'h300;
    tick();
    n_cmp++; if ({alloc_to_if_gr_out, alloc_to_lsb_r_en_out, mem_a} !== {2'b10, 32'h300}) begin n_bad++;
      $display("FAIL clr_idle_t3: fgr=%b rdone=%b a=%h", alloc_to_if_gr_out, alloc_to_lsb_r_en_out, mem_a); end
    if_to_alloc_en_in = 1'b0;
    tick(); tick(); tick(); tick();
    n_cmp++; if ({alloc_to_if_en_out, if_d_out} !== {1'b1, model_read(32'h300, 2'd3)}) begin n_bad++;
      $display("FAIL clr_fetch_after: done=%b d=%h", alloc_to_if_en_out, if_d_out); end
    tick();
    clear_branch_in = 1'b1;
    lsb_to_alloc_r_en_in = 1'b1; lsb_r_a_in = 32'h10; lsb_r_offset_in = 2'd0;
    tick();
    n_cmp++; if (alloc_to_lsb_r_gr_out !== 1'b0) begin n_bad++;
      $display("FAIL clr_blocks_grant: gr=%b want 0", alloc_to_lsb_r_gr_out); end
    clear_branch_in = 1'b0;
    tick();
    n_cmp++; if (alloc_to_lsb_r_gr_out !== 1'b1) begin n_bad++;
      $display("FAIL clr_grant_after: gr=%b want 1", alloc_to_lsb_r_gr_out); end
    lsb_to_alloc_r_en_in = 1'b0;
    tick(); tick();
    d = $urandom;
    lsb_to_alloc_w_en_in = 1'b1; lsb_w_a_in = 32'h400; lsb_w_offset_in = 2'd3; lsb_d_in = d;
    tick();
    lsb_to_alloc_w_en_in = 1'b0;
    tick(); tick();
    clear_branch_in = 1'b1;
    tick();
    clear_branch_in = 1'b0;
    n_cmp++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h403, d[31:24]}) begin n_bad++;
      $display("FAIL clr_store_byte3: wr=%b a=%h dout=%h want 1 00000403 %h", mem_wr, mem_a, mem_dout,
               d[31:24]); end
    tick();
    n_cmp++; if ({mem_wr, alloc_to_lsb_w_en_out} !== 2'b01) begin n_bad++;
      $display("FAIL clr_store_done: wr=%b done=%b want 0 1", mem_wr, alloc_to_lsb_w_en_out); end
    model_write(32'h400, 2'd3, d);
    tick();
  endtask

  task automatic test_rdy_hold();
    if_to_alloc_en_in = 1'b1; if_a_in = 32'h500;
    tick();
    if_to_alloc_en_in = 1'b0;
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if ({alloc_to_if_gr_out, mem_a} !== {1'b1, 32'h500}) begin n_bad++;
        $display("FAIL rdy_hold%0d: gr=%b a=%h want 1 00000500", i, alloc_to_if_gr_out, mem_a); end
    end
    rdy_in = 1'b1;
    tick();
    n_cmp++; if ({alloc_to_if_gr_out, mem_a} !== {1'b0, 32'h501}) begin n_bad++;
      $display("FAIL rdy_resume: gr=%b a=%h want 0 00000501", alloc_to_if_gr_out, mem_a); end
    tick(); tick(); tick();
    rdy_in = 1'b0;
    tick();
    n_cmp++; if ({alloc_to_if_en_out, if_d_out} !== {1'b1, model_read(32'h500, 2'd3)}) begin n_bad++;
      $display("FAIL rdy_done_stretch: done=%b d=%h", alloc_to_if_en_out, if_d_out); end
    rdy_in = 1'b1;
    tick();
    n_cmp++; if (alloc_to_if_en_out !== 1'b0) begin n_bad++;
      $display("FAIL rdy_done_drop: done=%b want 0", alloc_to_if_en_out); end
  endtask

  task automatic test_async_reset();
    lsb_to_alloc_w_en_in = 1'b1; lsb_w_a_in = 32'h600; lsb_w_offset_in = 2'd3; lsb_d_in = 32'h1234_5678;
    tick();
    lsb_to_alloc_w_en_in = 1'b0;
    tick();
    #2 rst_in = 1'b1;
    #1;
    n_cmp++; if ({mem_wr, mem_a, mem_dout, alloc_to_lsb_w_gr_out, alloc_to_lsb_w_en_out} !== 43'd0) begin
      n_bad++; $display("FAIL areset_outputs: wr=%b a=%h dout=%h want all 0", mem_wr, mem_a, mem_dout); end
    #2 rst_in = 1'b0;
    if_to_alloc_en_in = 1'b1; if_a_in = 32'h700;
    tick();
    n_cmp++; if ({alloc_to_if_gr_out, mem_a, mem_wr} !== {1'b1, 32'h700, 1'b0}) begin n_bad++;
      $display("FAIL areset_first_grant: gr=%b a=%h wr=%b", alloc_to_if_gr_out, mem_a, mem_wr); end
    if_to_alloc_en_in = 1'b0;
    tick(); tick(); tick(); tick();
    n_cmp++; if ({alloc_to_if_en_out, if_d_out} !== {1'b1, model_read(32'h700, 2'd3)}) begin n_bad++;
      $display("FAIL areset_fetch_done: done=%b d=%h", alloc_to_if_en_out, if_d_out); end
    tick();
  endtask

  task automatic test_random();
    logic        w_pend, r_pend, f_pend, full, is_w;
    logic [31:0] wa, ra, fa, wd, a, expd;
    logic [1:0]  wo, ro, o;
    logic [2:0]  kind;
    for (int it = 0; it < 40; it++) begin
      w_pend = 1'($urandom_range(0, 1));
      r_pend = 1'($urandom_range(0, 1));
      f_pend = 1'($urandom_range(0, 1));
      if (!(w_pend || r_pend || f_pend)) f_pend = 1'b1;
      wa = $urandom; ra = $urandom; fa = $urandom; wd = $urandom;
      if ($urandom_range(0, 2) == 0) wa[17:16] = 2'b11;
      if ($urandom_range(0, 3) == 0) ra = 32'hFFFF_FFFF - 32'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) fa = 32'hFFFF_FFFF - 32'($urandom_range(0, 2));
      wo = pick_off(); ro = pick_off();
      full = 1'($urandom_range(0, 1));
      io_buffer_full_in = full;
      lsb_to_alloc_w_en_in = w_pend; lsb_w_a_in = wa; lsb_w_offset_in = wo; lsb_d_in = wd;
      lsb_to_alloc_r_en_in = r_pend; lsb_r_a_in = ra; lsb_r_offset_in = ro;
      if_to_alloc_en_in = f_pend; if_a_in = fa;
      while (w_pend || r_pend || f_pend) begin
        if (w_pend && !(full && wa[17:16] == 2'b11)) begin kind = 3'b100; a = wa; o = wo; end
        else if (r_pend) begin kind = 3'b010; a = ra; o = ro; end
        else if (f_pend) begin kind = 3'b001; a = fa; o = 2'd3; end
        else begin
          for (int s = 0; s < 2; s++) begin
            tick();
            n_cmp++; if ({alloc_to_lsb_w_gr_out, mem_wr} !== 2'b00) begin n_bad++;
              $display("FAIL rnd_io_block it%0d: gr=%b wr=%b want 0 0", it, alloc_to_lsb_w_gr_out, mem_wr); end
          end
          full = 1'b0; io_buffer_full_in = 1'b0;
          continue;
        end
        is_w = kind[2];
        tick();
        n_cmp++; if ({alloc_to_lsb_w_gr_out, alloc_to_lsb_r_gr_out, alloc_to_if_gr_out} !== kind) begin
          n_bad++; $display("FAIL rnd_grant it%0d: got %b want %b", it,
            {alloc_to_lsb_w_gr_out, alloc_to_lsb_r_gr_out, alloc_to_if_gr_out}, kind); end
        if (kind[2]) begin w_pend = 1'b0; lsb_to_alloc_w_en_in = 1'b0; end
        if (kind[1]) begin r_pend = 1'b0; lsb_to_alloc_r_en_in = 1'b0; end
        if (kind[0]) begin f_pend = 1'b0; if_to_alloc_en_in = 1'b0; end
        for (int k = 0; k <= int'(o); k++) begin
          if (k > 0) tick();
          n_cmp++; if ({mem_a, mem_wr} !== {a + 32'(k), is_w}) begin n_bad++;
            $display("FAIL rnd_addr it%0d b%0d: a=%h wr=%b want %h %b", it, k, mem_a, mem_wr,
                     a + 32'(k), is_w); end
          if (is_w) begin
            n_cmp++; if (mem_dout !== wd[8*k +: 8]) begin n_bad++;
              $display("FAIL rnd_wbyte it%0d b%0d: dout=%h want %h", it, k, mem_dout, wd[8*k +: 8]); end
          end
          if (k > 0) begin
            n_cmp++; if ({alloc_to_lsb_w_en_out, alloc_to_lsb_r_en_out, alloc_to_if_en_out} !== 3'b000) begin
              n_bad++; $display("FAIL rnd_early_done it%0d b%0d: done asserted, want none", it, k); end
          end
        end
        tick();
        n_cmp++; if ({alloc_to_lsb_w_en_out, alloc_to_lsb_r_en_out, alloc_to_if_en_out} !== kind) begin
          n_bad++; $display("FAIL rnd_done it%0d: got %b want %b", it,
            {alloc_to_lsb_w_en_out, alloc_to_lsb_r_en_out, alloc_to_if_en_out}, kind); end
        if (is_w) begin
          n_cmp++; if (mem_wr !== 1'b0) begin n_bad++;
            $display("FAIL rnd_wr_drop it%0d: wr=%b want 0", it, mem_wr); end
          model_write(a, o, wd);
        end else begin
          expd = model_read(a, o);
          n_cmp++; if ((kind[1] ? lsb_d_out : if_d_out) !== expd) begin n_bad++;
            $display("FAIL rnd_rdata it%0d: got %h want %h", it, kind[1] ? lsb_d_out : if_d_out, expd); end
        end
      end
      io_buffer_full_in = 1'b0;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store_then_load();
    test_lb();
    test_io_stall();
    test_clear_branch();
    test_rdy_hold();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
